// File: rtl/vx_tl_dmem_adapter.sv
`default_nettype none
// ============================================================================
// Module   : vx_tl_dmem_adapter
// Brief    : Multi-lane Vortex dcache request/response to TileLink-UL A/D bridge
// Revision : 1.0 - initial release
// ============================================================================
module vx_tl_dmem_adapter #(
   parameter int NUM_LANES   = 4,
   parameter int TAG_WIDTH   = 10,
   parameter int NUM_SOURCES = 8,
   parameter int SRC_W       = $clog2(NUM_SOURCES)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      core_req_valid,
   input  logic                      core_req_rw,
   input  logic [NUM_LANES-1:0]      core_req_tmask,
   input  logic [4*NUM_LANES-1:0]    core_req_byteen,
   input  logic [30*NUM_LANES-1:0]   core_req_addr,
   input  logic [32*NUM_LANES-1:0]   core_req_data,
   input  logic [TAG_WIDTH-1:0]      core_req_tag,
   output logic                      core_req_ready,
   output logic                      core_rsp_valid,
   output logic [NUM_LANES-1:0]      core_rsp_tmask,
   output logic [32*NUM_LANES-1:0]   core_rsp_data,
   output logic [TAG_WIDTH-1:0]      core_rsp_tag,
   input  logic                      core_rsp_ready,
   output logic                      tl_a_valid,
   input  logic                      tl_a_ready,
   output logic [2:0]                tl_a_opcode,
   output logic [2:0]                tl_a_param,
   output logic [3:0]                tl_a_size,
   output logic [SRC_W-1:0]          tl_a_source,
   output logic [31:0]               tl_a_address,
   output logic [3:0]                tl_a_mask,
   output logic [31:0]               tl_a_data,
   output logic                      tl_a_corrupt,
   input  logic                      tl_d_valid,
   output logic                      tl_d_ready,
   input  logic [2:0]                tl_d_opcode,
   input  logic [SRC_W-1:0]          tl_d_source,
   input  logic [31:0]               tl_d_data,
   input  logic                      tl_d_denied,
   output logic                      busy,
   output logic                      err_pulse
);

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   localparam logic [2:0] c_put_full    = 3'd0;
   localparam logic [2:0] c_put_partial = 3'd1;
   localparam logic [2:0] c_get         = 3'd4;
   localparam logic [2:0] c_ack_data    = 3'd1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t                   r_state;
   logic                     r_rw;
   logic [NUM_LANES-1:0]     r_pending;
   logic [4*NUM_LANES-1:0]   r_byteen;
   logic [30*NUM_LANES-1:0]  r_addr;
   logic [32*NUM_LANES-1:0]  r_data;
   logic [TAG_WIDTH-1:0]     r_tag;
   logic                     r_a_hold;
   logic [SRC_W-1:0]         r_a_src;

   logic [NUM_SOURCES-1:0]   r_alloc;
   logic [TAG_WIDTH-1:0]     r_tbl_tag   [NUM_SOURCES];
   logic [LANE_W-1:0]        r_tbl_lane  [NUM_SOURCES];
   logic [NUM_SOURCES-1:0]   r_tbl_store;

   logic                     r_rsp_valid;
   logic [NUM_LANES-1:0]     r_rsp_tmask;
   logic [32*NUM_LANES-1:0]  r_rsp_data;
   logic [TAG_WIDTH-1:0]     r_rsp_tag;
   logic                     r_err;

   logic [LANE_W-1:0]        w_lane;
   logic [NUM_LANES-1:0]     w_lane_onehot;
   logic                     w_any_free;
   logic [SRC_W-1:0]         w_free_src;
   logic                     w_a_valid;
   logic [SRC_W-1:0]         w_a_src;
   logic                     w_a_fire;
   logic [3:0]               w_lane_byteen;
   logic [2:0]               w_opcode;
   logic                     w_d_ready;
   logic                     w_d_fire;
   logic                     w_d_known;
   logic                     w_d_rsp;
   logic [LANE_W-1:0]        w_d_lane;
   logic [NUM_LANES-1:0]     w_d_onehot;
   logic [32*NUM_LANES-1:0]  w_d_data;
   logic [NUM_SOURCES-1:0]   w_alloc_nxt;

   // Lowest pending lane and lowest free source (from registered allocation)
   always_comb begin
      w_lane        = '0;
      w_lane_onehot = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (r_pending[i]) w_lane = LANE_W'(i);
      end
      w_lane_onehot[w_lane] = 1'b1;
   end

   always_comb begin
      w_any_free = 1'b0;
      w_free_src = '0;
      for (int s = NUM_SOURCES - 1; s >= 0; s--) begin
         if (!r_alloc[s]) begin
            w_any_free = 1'b1;
            w_free_src = SRC_W'(s);
         end
      end
   end

   // A held beat keeps its captured source even if a lower one frees up
   assign w_a_valid     = reset && (r_state == ST_ISSUE) && (|r_pending) && (r_a_hold || w_any_free);
   assign w_a_src       = r_a_hold ? r_a_src : w_free_src;
   assign w_a_fire      = w_a_valid && tl_a_ready;
   assign w_lane_byteen = r_byteen[w_lane*4 +: 4];
   assign w_opcode      = !r_rw ? c_get : ((w_lane_byteen == 4'hf) ? c_put_full : c_put_partial);

   assign w_d_ready  = reset && (!r_rsp_valid || core_rsp_ready);
   assign w_d_fire   = tl_d_valid && w_d_ready;
   assign w_d_known  = r_alloc[tl_d_source];
   assign w_d_rsp    = w_d_fire && w_d_known && (tl_d_opcode == c_ack_data) && !r_tbl_store[tl_d_source];
   assign w_d_lane   = r_tbl_lane[tl_d_source];

   always_comb begin
      w_d_onehot           = '0;
      w_d_onehot[w_d_lane] = 1'b1;
      w_d_data             = '0;
      if (!tl_d_denied) w_d_data[w_d_lane*32 +: 32] = tl_d_data;
   end

   always_comb begin
      w_alloc_nxt = r_alloc;
      if (w_d_fire && w_d_known) w_alloc_nxt[tl_d_source] = 1'b0;
      if (w_a_fire)              w_alloc_nxt[w_a_src]     = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_rw        <= 1'b0;
         r_pending   <= '0;
         r_a_hold    <= 1'b0;
         r_a_src     <= '0;
         r_alloc     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_tmask <= '0;
         r_rsp_data  <= '0;
         r_rsp_tag   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_alloc <= w_alloc_nxt;
         r_err   <= w_d_fire && (!w_d_known || tl_d_denied);

         case (r_state)
            ST_IDLE: begin
               if (core_req_valid) begin
                  r_rw      <= core_req_rw;
                  r_pending <= core_req_tmask;
                  r_state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_a_hold <= w_a_valid && !tl_a_ready;
               r_a_src  <= w_a_src;
               if (w_a_fire) r_pending <= r_pending & ~w_lane_onehot;
               if (r_pending == '0 || (w_a_fire && (r_pending & ~w_lane_onehot) == '0))
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_d_rsp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_tmask <= w_d_onehot;
            r_rsp_data  <= w_d_data;
            r_rsp_tag   <= r_tbl_tag[tl_d_source];
         end else if (core_rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   // Request payload and source table need no reset: validity is tracked elsewhere
   always_ff @(posedge clock) begin
      if (core_req_ready && core_req_valid) begin
         r_byteen <= core_req_byteen;
         r_addr   <= core_req_addr;
         r_data   <= core_req_data;
         r_tag    <= core_req_tag;
      end
      if (w_a_fire) begin
         r_tbl_tag[w_a_src]   <= r_tag;
         r_tbl_lane[w_a_src]  <= w_lane;
         r_tbl_store[w_a_src] <= r_rw;
      end
   end

   assign core_req_ready = reset && (r_state == ST_IDLE);
   assign core_rsp_valid = r_rsp_valid;
   assign core_rsp_tmask = r_rsp_tmask;
   assign core_rsp_data  = r_rsp_data;
   assign core_rsp_tag   = r_rsp_tag;

   assign tl_a_valid   = w_a_valid;
   assign tl_a_opcode  = w_a_valid ? w_opcode : 3'd0;
   assign tl_a_param   = 3'd0;
   assign tl_a_size    = w_a_valid ? 4'd2 : 4'd0;
   assign tl_a_source  = w_a_valid ? w_a_src : '0;
   assign tl_a_address = w_a_valid ? {r_addr[w_lane*30 +: 30], 2'b00} : 32'd0;
   assign tl_a_mask    = w_a_valid ? (r_rw ? w_lane_byteen : 4'hf) : 4'h0;
   assign tl_a_data    = (w_a_valid && r_rw) ? r_data[w_lane*32 +: 32] : 32'd0;
   assign tl_a_corrupt = 1'b0;

   assign tl_d_ready = w_d_ready;
   assign busy       = (r_state == ST_ISSUE) || (|r_alloc) || r_rsp_valid;
   assign err_pulse  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vx_tl_dmem_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_tl_dmem_adapter
// Brief    : Directed, table-driven self-checking bench for vx_tl_dmem_adapter
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_tl_dmem_adapter;

   logic          clock = 1'b0;
   logic          reset;
   logic          core_req_valid;
   logic          core_req_rw;
   logic [3:0]    core_req_tmask;
   logic [15:0]   core_req_byteen;
   logic [119:0]  core_req_addr;
   logic [127:0]  core_req_data;
   logic [9:0]    core_req_tag;
   logic          core_req_ready;
   logic          core_rsp_valid;
   logic [3:0]    core_rsp_tmask;
   logic [127:0]  core_rsp_data;
   logic [9:0]    core_rsp_tag;
   logic          core_rsp_ready;
   logic          tl_a_valid;
   logic          tl_a_ready;
   logic [2:0]    tl_a_opcode;
   logic [2:0]    tl_a_param;
   logic [3:0]    tl_a_size;
   logic [2:0]    tl_a_source;
   logic [31:0]   tl_a_address;
   logic [3:0]    tl_a_mask;
   logic [31:0]   tl_a_data;
   logic          tl_a_corrupt;
   logic          tl_d_valid;
   logic          tl_d_ready;
   logic [2:0]    tl_d_opcode;
   logic [2:0]    tl_d_source;
   logic [31:0]   tl_d_data;
   logic          tl_d_denied;
   logic          busy;
   logic          err_pulse;

   int n_vec = 0;
   int n_err = 0;

   vx_tl_dmem_adapter dut (
      .clock(clock), .reset(reset),
      .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
      .core_req_tmask(core_req_tmask), .core_req_byteen(core_req_byteen),
      .core_req_addr(core_req_addr), .core_req_data(core_req_data),
      .core_req_tag(core_req_tag), .core_req_ready(core_req_ready),
      .core_rsp_valid(core_rsp_valid), .core_rsp_tmask(core_rsp_tmask),
      .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
      .core_rsp_ready(core_rsp_ready),
      .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
      .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
      .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
      .tl_a_corrupt(tl_a_corrupt),
      .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
      .tl_d_source(tl_d_source), .tl_d_data(tl_d_data), .tl_d_denied(tl_d_denied),
      .busy(busy), .err_pulse(err_pulse)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      int          lane;
      logic        rw;
      logic [3:0]  be;
      logic [29:0] addr;
      logic [31:0] data;
      logic [31:0] d_data;
      logic [2:0]  x_op;
      logic [3:0]  x_mask;
      logic [31:0] x_addr;
      logic [31:0] x_data;
   } vec_t;

   vec_t          tbl [6];
   logic [15:0]   t_be;
   logic [119:0]  t_ad;
   logic [127:0]  t_dt;
   logic [127:0]  t_rsp;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_req(input logic rw, input logic [3:0] tm, input logic [15:0] be,
                           input logic [119:0] ad, input logic [127:0] dt, input logic [9:0] tg);
      core_req_valid  = 1'b1;
      core_req_rw     = rw;
      core_req_tmask  = tm;
      core_req_byteen = be;
      core_req_addr   = ad;
      core_req_data   = dt;
      core_req_tag    = tg;
      #1;
      check("req_ready", core_req_ready, 1'b1);
      tick();
      core_req_valid = 1'b0;
   endtask

   task automatic d_beat(input logic [2:0] src, input logic [2:0] op,
                         input logic [31:0] dd, input logic den);
      tl_d_valid  = 1'b1;
      tl_d_source = src;
      tl_d_opcode = op;
      tl_d_data   = dd;
      tl_d_denied = den;
      #1;
      check("d_ready", tl_d_ready, 1'b1);
      tick();
      tl_d_valid  = 1'b0;
      tl_d_denied = 1'b0;
   endtask

   initial begin
      tbl[0] = '{0, 1'b0, 4'h0, 30'h40,       32'h11111111, 32'hCAFE0000, 3'd4, 4'hf, 32'h00000100, 32'h0};
      tbl[1] = '{1, 1'b1, 4'hf, 30'h1,        32'hDEADBEEF, 32'h0,        3'd0, 4'hf, 32'h00000004, 32'hDEADBEEF};
      tbl[2] = '{2, 1'b1, 4'h3, 30'h3FFFFFFF, 32'h12345678, 32'h0,        3'd1, 4'h3, 32'hFFFFFFFC, 32'h12345678};
      tbl[3] = '{3, 1'b1, 4'h0, 30'h2AAAAAAA, 32'h0F0F0F0F, 32'h0,        3'd1, 4'h0, 32'hAAAAAAA8, 32'h0F0F0F0F};
      tbl[4] = '{3, 1'b0, 4'h3, 30'h155,      32'hFFFFFFFF, 32'h87654321, 3'd4, 4'hf, 32'h00000554, 32'h0};
      tbl[5] = '{2, 1'b1, 4'h8, 30'h0,        32'h80000000, 32'h0,        3'd1, 4'h8, 32'h00000000, 32'h80000000};

      reset = 1'b0; core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_tmask = '0;
      core_req_byteen = '0; core_req_addr = '0; core_req_data = '0; core_req_tag = '0;
      core_rsp_ready = 1'b1; tl_a_ready = 1'b1; tl_d_valid = 1'b0; tl_d_opcode = '0;
      tl_d_source = '0; tl_d_data = '0; tl_d_denied = 1'b0;

      // Power-on reset
      tick(); tick();
      check("rst_req_ready", core_req_ready, 1'b0);
      check("rst_d_ready",   tl_d_ready, 1'b0);
      check("rst_outputs",   {tl_a_valid, core_rsp_valid, busy, err_pulse, tl_a_address}, '0);
      reset = 1'b1;
      #1;
      check("post_rst_ready", {core_req_ready, tl_d_ready}, 2'b11);

      // Single-lane vector table
      for (int i = 0; i < 6; i++) begin
         t_be = 16'h5555;
         t_be[tbl[i].lane*4 +: 4] = tbl[i].be;
         for (int k = 0; k < 4; k++) t_ad[k*30 +: 30] = 30'h3FF0000 + 30'(k);
         t_ad[tbl[i].lane*30 +: 30] = tbl[i].addr;
         t_dt = {4{32'hA5A5A5A5}};
         t_dt[tbl[i].lane*32 +: 32] = tbl[i].data;
         t_rsp = '0;
         t_rsp[tbl[i].lane*32 +: 32] = tbl[i].d_data;
         send_req(tbl[i].rw, 4'(1 << tbl[i].lane), t_be, t_ad, t_dt, 10'(9'h100 + i));
         #1;
         check($sformatf("vec%0d_a", i),
               {tl_a_valid, tl_a_opcode, tl_a_mask, tl_a_address, tl_a_data, tl_a_source, tl_a_size},
               {1'b1, tbl[i].x_op, tbl[i].x_mask, tbl[i].x_addr, tbl[i].x_data, 3'd0, 4'd2});
         tick();
         d_beat(3'd0, tbl[i].rw ? 3'd0 : 3'd1, tbl[i].d_data, 1'b0);
         #1;
         if (!tbl[i].rw)
            check($sformatf("vec%0d_rsp", i), {core_rsp_valid, core_rsp_tmask, core_rsp_tag, core_rsp_data},
                  {1'b1, 4'(1 << tbl[i].lane), 10'(9'h100 + i), t_rsp});
         else
            check($sformatf("vec%0d_norsp", i), core_rsp_valid, 1'b0);
         tick();
      end

      // Empty tmask: one ISSUE cycle, no traffic
      send_req(1'b0, 4'b0000, '0, '0, '0, 10'h5);
      #1;
      check("tm0_issue", {core_req_ready, tl_a_valid, busy}, 3'b001);
      tick();
      check("tm0_back_idle", {core_req_ready, busy}, 2'b10);

      // Multi-lane load, out-of-order D replies
      send_req(1'b0, 4'b1011, '0, {30'h10C, 30'h0, 30'h104, 30'h100}, '0, 10'h2A);
      #1; check("ld_beat0", {tl_a_valid, tl_a_opcode, tl_a_source, tl_a_address}, {1'b1, 3'd4, 3'd0, 32'h400}); tick();
      #1; check("ld_beat1", {tl_a_valid, tl_a_opcode, tl_a_source, tl_a_address}, {1'b1, 3'd4, 3'd1, 32'h410}); tick();
      #1; check("ld_beat2", {tl_a_valid, tl_a_opcode, tl_a_source, tl_a_address}, {1'b1, 3'd4, 3'd2, 32'h430}); tick();
      #1; check("ld_idle", {core_req_ready, tl_a_valid}, 2'b10);
      tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_source = 3'd2; tl_d_data = 32'hD0000002;
      #1; tick();
      tl_d_source = 3'd0; tl_d_data = 32'hD0000000;
      #1; check("ooo_rsp0", {core_rsp_valid, tl_d_ready, core_rsp_tmask, core_rsp_tag, core_rsp_data},
                {2'b11, 4'b1000, 10'h2A, 128'hD0000002_00000000_00000000_00000000});
      tick();
      tl_d_source = 3'd1; tl_d_data = 32'hD0000001;
      #1; check("ooo_rsp1", {core_rsp_valid, core_rsp_tmask, core_rsp_tag, core_rsp_data},
                {1'b1, 4'b0001, 10'h2A, 128'h00000000_00000000_00000000_D0000000});
      tick();
      tl_d_valid = 1'b0;
      #1; check("ooo_rsp2", {core_rsp_valid, core_rsp_tmask, core_rsp_tag, core_rsp_data},
                {1'b1, 4'b0010, 10'h2A, 128'h00000000_00000000_D0000001_00000000});
      tick();
      check("ooo_drained", {core_rsp_valid, busy}, 2'b00);

      // Stores: full then partial, acks absorbed
      send_req(1'b1, 4'b0011, 16'h003F, {30'h0, 30'h0, 30'h21, 30'h20},
               {32'h0, 32'h0, 32'h22222222, 32'h11111111}, 10'h7);
      #1; check("st_beat0", {tl_a_opcode, tl_a_mask, tl_a_source, tl_a_data}, {3'd0, 4'hf, 3'd0, 32'h11111111}); tick();
      #1; check("st_beat1", {tl_a_opcode, tl_a_mask, tl_a_source, tl_a_data}, {3'd1, 4'h3, 3'd1, 32'h22222222}); tick();
      tl_d_valid = 1'b1; tl_d_opcode = 3'd0; tl_d_source = 3'd0;
      #1; check("st_ack0_busy", busy, 1'b1); tick();
      tl_d_source = 3'd1;
      #1; check("st_ack1_busy", {busy, core_rsp_valid}, 2'b10); tick();
      tl_d_valid = 1'b0;
      #1; check("st_done", {busy, core_rsp_valid, err_pulse}, 3'b000);

      // Fill all sources, then stall until source 5 is freed
      send_req(1'b0, 4'b1111, '0, '0, '0, 10'h11);
      for (int k = 0; k < 4; k++) begin
         #1; check($sformatf("fill_src%0d", k), {tl_a_valid, tl_a_source}, {1'b1, 3'(k)}); tick();
      end
      send_req(1'b0, 4'b1111, '0, '0, '0, 10'h22);
      for (int k = 4; k < 8; k++) begin
         #1; check($sformatf("fill_src%0d", k), {tl_a_valid, tl_a_source}, {1'b1, 3'(k)}); tick();
      end
      send_req(1'b0, 4'b0001, '0, {90'h0, 30'h77}, '0, 10'h33);
      #1; check("full_stall0", tl_a_valid, 1'b0); tick();
      #1; check("full_stall1", tl_a_valid, 1'b0);
      tl_d_valid = 1'b1; tl_d_opcode = 3'd0; tl_d_source = 3'd5;
      #1; check("full_same_cycle", {tl_a_valid, tl_d_ready}, 2'b01); tick();
      tl_d_valid = 1'b0;
      #1; check("full_reuse5", {tl_a_valid, tl_a_source, tl_a_address}, {1'b1, 3'd5, 32'h1DC}); tick();
      #1; check("full_after", {tl_a_valid, core_req_ready}, 2'b01);
      for (int s = 0; s < 8; s++) d_beat(3'(s), 3'd0, 32'h0, 1'b0);
      #1; check("full_freed", busy, 1'b0);

      // A-channel stall with a lower source freed mid-stall
      send_req(1'b0, 4'b0111, '0, {30'h0, 30'h52, 30'h51, 30'h50}, '0, 10'h44);
      #1; check("stl_beat0", {tl_a_valid, tl_a_source}, {1'b1, 3'd0}); tick();
      tl_a_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin tl_d_valid = 1'b1; tl_d_opcode = 3'd0; tl_d_source = 3'd0; end
         if (c == 2) tl_d_valid = 1'b0;
         if (c == 3) tl_a_ready = 1'b1;
         #1; check($sformatf("stl_hold%0d", c), {tl_a_valid, tl_a_opcode, tl_a_source, tl_a_address, tl_a_mask},
                   {1'b1, 3'd4, 3'd1, 32'h144, 4'hf});
         tick();
      end
      #1; check("stl_beat2", {tl_a_valid, tl_a_source, tl_a_address}, {1'b1, 3'd0, 32'h148}); tick();
      #1; check("stl_idle", core_req_ready, 1'b1);
      d_beat(3'd1, 3'd0, 32'h0, 1'b0);
      d_beat(3'd0, 3'd0, 32'h0, 1'b0);

      // Response backpressure
      send_req(1'b0, 4'b0011, '0, {30'h0, 30'h0, 30'h61, 30'h60}, '0, 10'h55);
      tick(); tick();
      core_rsp_ready = 1'b0;
      d_beat(3'd0, 3'd1, 32'hAAAA0001, 1'b0);
      tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_source = 3'd1; tl_d_data = 32'hBBBB0002;
      for (int c = 0; c < 2; c++) begin
         #1; check($sformatf("bp_hold%0d", c), {tl_d_ready, core_rsp_valid, core_rsp_tmask, core_rsp_tag, core_rsp_data},
                   {2'b01, 4'b0001, 10'h55, 128'h0000_0000_0000_0000_0000_0000_AAAA_0001});
         tick();
      end
      core_rsp_ready = 1'b1;
      #1; check("bp_release", tl_d_ready, 1'b1); tick();
      tl_d_valid = 1'b0;
      #1; check("bp_second", {core_rsp_valid, core_rsp_tmask, core_rsp_data},
                {1'b1, 4'b0010, 128'h0000_0000_0000_0000_BBBB_0002_0000_0000});
      tick();
      check("bp_drained", {core_rsp_valid, busy}, 2'b00);

      // Denied load: response with zero data plus error pulse
      send_req(1'b0, 4'b0100, '0, {30'h0, 30'h70, 60'h0}, '0, 10'h3FF);
      tick();
      tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_source = 3'd0; tl_d_data = 32'hFFFFFFFF; tl_d_denied = 1'b1;
      #1; check("den_pre_err", err_pulse, 1'b0); tick();
      tl_d_valid = 1'b0; tl_d_denied = 1'b0;
      #1; check("den_rsp", {err_pulse, core_rsp_valid, core_rsp_tmask, core_rsp_tag, core_rsp_data},
                {2'b11, 4'b0100, 10'h3FF, 128'h0});
      tick();
      check("den_pulse_end", {err_pulse, core_rsp_valid}, 2'b00);

      // Reset mid-ISSUE with three sources outstanding
      send_req(1'b0, 4'b1111, '0, {30'h3, 30'h2, 30'h1, 30'h0}, '0, 10'h66);
      tick(); tick(); tick();
      tl_a_ready = 1'b0;
      #1; check("mid_stall", {tl_a_valid, tl_a_source}, {1'b1, 3'd3});
      reset = 1'b0;
      #1; check("in_rst_ready", {core_req_ready, tl_d_ready, tl_a_valid}, 3'b000);
      tick();
      check("rst_all_zero", {core_req_ready, tl_d_ready, tl_a_valid, tl_a_source, tl_a_address,
                             tl_a_opcode, core_rsp_valid, busy, err_pulse}, '0);
      reset = 1'b1; tl_a_ready = 1'b1;
      #1; check("rst_release", {core_req_ready, busy}, 2'b10);
      d_beat(3'd1, 3'd1, 32'h12345678, 1'b0);
      check("stale_src_err", {err_pulse, core_rsp_valid, busy}, 3'b100);
      tick();
      check("stale_err_end", err_pulse, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
